// File: rtl/biquad_stereo_sequencer.sv
// Stereo front-end for two external mono biquad cores: frame handshake, core
// enable/capture sequencing, double-buffered coefficients and flush control.
module biquad_stereo_sequencer #(
  parameter int CORE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data_l,
  input  logic [15:0] s_data_r,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data_l,
  output logic [15:0] m_data_r,
  output logic        core_en,
  output logic        core_rst,
  output logic [15:0] core_x_l,
  output logic [15:0] core_x_r,
  input  logic [15:0] core_y_l,
  input  logic [15:0] core_y_r,
  output logic [15:0] coef_b0,
  output logic [15:0] coef_b1,
  output logic [15:0] coef_b2,
  output logic [15:0] coef_a1,
  output logic [15:0] coef_a2,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic        cfg_commit,
  output logic        cfg_pending,
  input  logic        flush
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  localparam logic [2:0] LAST = 3'(CORE_LAT - 1);
  // index 0 = b0 ... 4 = a2; reset set is a unity passthrough
  localparam logic [4:0][15:0] COEF_RST = {16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF};

  state_t           state, state_nx;
  logic [2:0]       wcnt;
  logic             rst_n_q, flush_pend;
  logic             apply_cfg, apply_flush;
  logic [4:0][15:0] shadow, active;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (s_valid && s_ready) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (wcnt == LAST) state_nx = OUT;
      OUT:   if (m_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    apply_cfg   = (state == IDLE) && cfg_pending;
    apply_flush = (state == IDLE) && flush_pend;
    s_ready     = (state == IDLE) && !rst_n_q && !flush_pend && !cfg_pending;
    core_en     = (state == ISSUE);
    m_valid     = (state == OUT);
    core_rst    = rst_n_q || apply_flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_q     <= 1'b1;
      wcnt        <= '0;
      core_x_l    <= '0;
      core_x_r    <= '0;
      m_data_l    <= '0;
      m_data_r    <= '0;
      cfg_pending <= 1'b0;
      flush_pend  <= 1'b0;
      shadow      <= COEF_RST;
      active      <= COEF_RST;
    end else begin
      rst_n_q <= 1'b0;
      if (s_valid && s_ready) begin
        core_x_l <= s_data_l;
        core_x_r <= s_data_r;
      end
      if (state == ISSUE)     wcnt <= '0;
      else if (state == WAIT) wcnt <= wcnt + 3'd1;
      if (state == WAIT && wcnt == LAST) begin
        m_data_l <= core_y_l;
        m_data_r <= core_y_r;
      end
      // a write landing on the apply edge stays in shadow for the next commit
      for (int i = 0; i < 5; i++)
        if (cfg_we && cfg_addr == 3'(i)) shadow[i] <= cfg_wdata;
      if (apply_cfg) active <= shadow;
      cfg_pending <= (cfg_pending && !apply_cfg) || cfg_commit;
      flush_pend  <= (flush_pend && !apply_flush) || flush;
    end
  end

  assign coef_b0 = active[0];
  assign coef_b1 = active[1];
  assign coef_b2 = active[2];
  assign coef_a1 = active[3];
  assign coef_a2 = active[4];

endmodule

// File: tb/tb_biquad_stereo_sequencer.sv
// Bench for biquad_stereo_sequencer: drives a behavioural biquad core pair and
// checks directed vectors, corner sequences and a randomized scoreboard run.
module tb_biquad_stereo_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [15:0] s_data_l, s_data_r, m_data_l, m_data_r;
  logic        core_en, core_rst;
  logic [15:0] core_x_l, core_x_r, core_y_l, core_y_r;
  logic [15:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
  logic        cfg_we, cfg_commit, cfg_pending, flush;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  biquad_stereo_sequencer #(.CORE_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data_l(s_data_l), .s_data_r(s_data_r),
    .m_valid(m_valid), .m_ready(m_ready), .m_data_l(m_data_l), .m_data_r(m_data_r),
    .core_en(core_en), .core_rst(core_rst), .core_x_l(core_x_l), .core_x_r(core_x_r),
    .core_y_l(core_y_l), .core_y_r(core_y_r),
    .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_b2(coef_b2), .coef_a1(coef_a1), .coef_a2(coef_a2),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_pending(cfg_pending), .flush(flush)
  );

  // external mono biquad cores, one-cycle latency
  logic [15:0] lx1, lx2, ly1, ly2, rx1, rx2, ry1, ry2;

  function automatic logic [15:0] bq(input logic [15:0] x, x1, x2, y1, y2);
    logic signed [39:0] acc;
    acc = $signed(coef_b0) * $signed(x) + $signed(coef_b1) * $signed(x1)
        + $signed(coef_b2) * $signed(x2) - $signed(coef_a1) * $signed(y1)
        - $signed(coef_a2) * $signed(y2);
    return acc[30:15];
  endfunction

  always_ff @(posedge clk) begin
    if (core_rst) begin
      {lx1, lx2, ly1, ly2, rx1, rx2, ry1, ry2} <= '0;
      core_y_l <= '0;
      core_y_r <= '0;
    end else if (core_en) begin
      core_y_l <= bq(core_x_l, lx1, lx2, ly1, ly2);
      core_y_r <= bq(core_x_r, rx1, rx2, ry1, ry2);
      lx1 <= core_x_l; lx2 <= lx1; ly1 <= bq(core_x_l, lx1, lx2, ly1, ly2); ly2 <= ly1;
      rx1 <= core_x_r; rx2 <= rx1; ry1 <= bq(core_x_r, rx1, rx2, ry1, ry2); ry2 <= ry1;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [15:0] l, input logic [15:0] r,
                           output logic [15:0] ol, output logic [15:0] orr);
    int n;
    s_valid = 1'b1; s_data_l = l; s_data_r = r; n = 0;
    while (!s_ready && n < 50) begin tick; n++; end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    tick;
    s_valid = 1'b0; n = 0;
    while (!m_valid && n < 50) begin tick; n++; end
    if (n >= 50) chk("output_timeout", 32'(n), 32'd0);
    ol = m_data_l; orr = m_data_r;
    tick;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; tick; cfg_we = 1'b0;
  endtask

  typedef struct {
    logic [15:0] xl, xr, el, er;
  } vec_t;
  vec_t tbl[6];

  logic [15:0] ol, orr, hl, hr;
  logic [31:0] expq[$];
  logic [31:0] e;
  logic [15:0] prev_l, prev_r;
  logic        stall_prev, drain;
  int          cnt_rdy, cnt_en, cnt_out, n_in;

  localparam logic [15:0] RB0 = 16'h6000;
  localparam logic [15:0] RB1 = 16'h1000;

  function automatic logic [15:0] ref_fir(input logic [15:0] x, input logic [15:0] xp);
    logic signed [31:0] p;
    p = $signed(RB0) * $signed(x) + $signed(RB1) * $signed(xp);
    return p[30:15];
  endfunction

  initial begin
    tbl[0] = '{16'h4000, 16'hC000, 16'h3FFF, 16'hC000};
    tbl[1] = '{16'h0000, 16'h7FFF, 16'h0000, 16'h7FFE};
    tbl[2] = '{16'h8000, 16'h0001, 16'h8001, 16'h0000};
    tbl[3] = '{16'hFFFF, 16'h1234, 16'hFFFF, 16'h1233};
    tbl[4] = '{16'h7FFF, 16'h8000, 16'h7FFE, 16'h8001};
    tbl[5] = '{16'h1234, 16'hFFFF, 16'h1233, 16'hFFFF};

    rst_n = 1'b0; s_valid = 1'b0; s_data_l = '0; s_data_r = '0; m_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0; flush = 1'b0;
    tick; tick; tick;

    // reset state
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_core_x", {core_x_l, core_x_r}, 32'h0);
    chk("rst_m_data", {m_data_l, m_data_r}, 32'h0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    chk("rst_coef_b0", 32'(coef_b0), 32'h7FFF);
    chk("rst_coef_rest", {coef_b1 | coef_b2, coef_a1 | coef_a2}, 32'h0);
    rst_n = 1'b1;
    chk("post_rst_c1_ready", 32'(s_ready), 32'd0);
    chk("post_rst_c1_core_rst", 32'(core_rst), 32'd1);
    tick;
    chk("post_rst_c2_ready", 32'(s_ready), 32'd1);
    chk("post_rst_c2_core_rst", 32'(core_rst), 32'd0);

    // first frame latency
    s_valid = 1'b1; s_data_l = 16'h4000; s_data_r = 16'hC000;
    tick; s_valid = 1'b0;
    chk("lat_issue_core_en", 32'(core_en), 32'd1);
    chk("lat_issue_core_x", {core_x_l, core_x_r}, 32'h4000C000);
    chk("lat_issue_m_valid", 32'(m_valid), 32'd0);
    tick;
    chk("lat_wait_core_en", 32'(core_en), 32'd0);
    chk("lat_wait_m_valid", 32'(m_valid), 32'd0);
    tick;
    chk("lat_out_m_valid", 32'(m_valid), 32'd1);
    chk("lat_out_data", {m_data_l, m_data_r}, 32'h3FFFC000);
    tick;
    chk("lat_back_idle", 32'(s_ready), 32'd1);

    // passthrough vectors
    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].xl, tbl[i].xr, ol, orr);
      chk($sformatf("vec%0d", i), {ol, orr}, {tbl[i].el, tbl[i].er});
    end

    // reset mid-frame abandons it
    s_valid = 1'b1; s_data_l = 16'h1111; s_data_r = 16'h2222;
    tick; s_valid = 1'b0; tick;
    rst_n = 1'b0; tick;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    chk("midrst_data", {core_x_l, m_data_l}, 32'h0);
    rst_n = 1'b1;
    chk("midrst_ready_c1", 32'(s_ready), 32'd0);
    tick;
    chk("midrst_ready_c2", 32'(s_ready), 32'd1);
    chk("midrst_no_out", 32'(m_valid), 32'd0);

    // back-to-back frames
    cnt_rdy = 0; cnt_en = 0; cnt_out = 0;
    s_valid = 1'b1; s_data_l = 16'h1234; s_data_r = 16'h1234; m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (s_ready) cnt_rdy++;
      if (core_en) cnt_en++;
      if (m_valid) begin
        cnt_out++;
        chk("b2b_data", {m_data_l, m_data_r}, 32'h12331233);
      end
      tick;
    end
    s_valid = 1'b0;
    chk("b2b_ready_pulses", 32'(cnt_rdy), 32'd4);
    chk("b2b_core_en", 32'(cnt_en), 32'd4);
    chk("b2b_outputs", 32'(cnt_out), 32'd4);

    // output stall
    m_ready = 1'b0; s_valid = 1'b1; s_data_l = 16'h7FFF; s_data_r = 16'h7FFF;
    tick; s_data_l = 16'h0000; s_data_r = 16'h0000;
    for (int n = 0; n < 10 && !m_valid; n++) tick;
    hl = m_data_l; hr = m_data_r;
    chk("stall_first", {hl, hr}, 32'h7FFE7FFE);
    cnt_en = 0; cnt_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (core_en) cnt_en++;
      if (s_ready) cnt_rdy++;
      chk("stall_hold", {m_data_l, m_data_r, 15'd0, m_valid}, {hl, hr, 16'd1});
    end
    chk("stall_no_core_en", 32'(cnt_en), 32'd0);
    chk("stall_no_ready", 32'(cnt_rdy), 32'd0);
    s_valid = 1'b0; m_ready = 1'b1; tick;
    chk("stall_release", {31'd0, s_ready}, {31'd0, !m_valid});

    // commit requested during WAIT
    m_ready = 1'b0; s_valid = 1'b1; s_data_l = 16'h4000; s_data_r = 16'h4000;
    chk("cmt_ready", 32'(s_ready), 32'd1);
    tick; s_valid = 1'b0; tick;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 16'h2000; cfg_commit = 1'b1;
    tick; cfg_we = 1'b0; cfg_commit = 1'b0;
    chk("cmt_out_pending", {cfg_pending, m_valid}, 32'd3);
    chk("cmt_out_b0_old", 32'(coef_b0), 32'h7FFF);
    tick;
    chk("cmt_stall_pending", 32'(cfg_pending), 32'd1);
    chk("cmt_frame_old_coef", {m_data_l, m_data_r}, 32'h3FFF3FFF);
    m_ready = 1'b1; tick;
    chk("cmt_apply_cycle", {s_ready, cfg_pending, m_valid}, 32'b010);
    tick;
    chk("cmt_applied_b0", 32'(coef_b0), 32'h2000);
    chk("cmt_applied_flags", {cfg_pending, s_ready}, 32'b01);
    run_frame(16'h4000, 16'h4000, ol, orr);
    chk("cmt_new_frame", {ol, orr}, 32'h10001000);

    // write on the apply edge stays in shadow; addr 5 ignored
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 16'h5000; cfg_commit = 1'b1;
    tick; cfg_commit = 1'b0; cfg_wdata = 16'h1000;
    tick; cfg_we = 1'b0;
    chk("coinc_b0_prior", 32'(coef_b0), 32'h5000);
    chk("coinc_pending", 32'(cfg_pending), 32'd0);
    cfg_write(3'd5, 16'hAAAA);
    cfg_commit = 1'b1; tick; cfg_commit = 1'b0; tick;
    chk("coinc_next_b0", 32'(coef_b0), 32'h1000);
    chk("addr5_ignored", {coef_b1 | coef_b2, coef_a1 | coef_a2}, 32'h0);

    // flush mid-frame
    cfg_write(3'd0, 16'h4000);
    cfg_write(3'd1, 16'h4000);
    cfg_commit = 1'b1; tick; cfg_commit = 1'b0; tick;
    s_valid = 1'b1; s_data_l = 16'h4000; s_data_r = 16'h4000;
    tick; s_valid = 1'b0; tick;
    flush = 1'b1; tick; flush = 1'b0;
    chk("flush_frame_out", {m_data_l, m_data_r}, 32'h40004000);
    tick;
    chk("flush_core_rst_idle", {core_rst, s_ready}, 32'b10);
    tick;
    chk("flush_core_rst_done", {core_rst, s_ready}, 32'b01);
    run_frame(16'h4000, 16'h4000, ol, orr);
    chk("flush_impulse0", {ol, orr}, 32'h20002000);
    run_frame(16'h0000, 16'h0000, ol, orr);
    chk("flush_impulse1", {ol, orr}, 32'h20002000);

    // randomized run against an FIR reference of the committed taps
    cfg_write(3'd0, RB0);
    cfg_write(3'd1, RB1);
    cfg_commit = 1'b1; tick; cfg_commit = 1'b0; tick;
    prev_l = '0; prev_r = '0; stall_prev = 1'b0; n_in = 0; cnt_out = 0; cnt_en = 0;
    for (int i = 0; i < 2030; i++) begin
      drain = (i >= 2000);
      s_valid = !drain && ($urandom_range(0, 2) != 0);
      s_data_l = 16'($urandom); s_data_r = 16'($urandom);
      m_ready = drain || ($urandom_range(0, 3) != 0);
      flush = !drain && ($urandom_range(0, 63) == 0);
      if (stall_prev) chk("rnd_hold", {m_data_l, m_data_r}, {hl, hr});
      if (s_valid && s_ready) begin
        expq.push_back({ref_fir(s_data_l, prev_l), ref_fir(s_data_r, prev_r)});
        prev_l = s_data_l; prev_r = s_data_r; n_in++;
      end
      if (flush) begin prev_l = '0; prev_r = '0; end
      if (m_valid && m_ready) begin
        cnt_out++;
        if (expq.size() == 0) chk("rnd_unexpected_out", 32'd1, 32'd0);
        else begin
          e = expq.pop_front();
          chk("rnd_data", {m_data_l, m_data_r}, e);
        end
      end
      if (core_en) cnt_en++;
      stall_prev = m_valid && !m_ready; hl = m_data_l; hr = m_data_r;
      tick;
    end
    flush = 1'b0;
    chk("rnd_in_out", 32'(cnt_out), 32'(n_in));
    chk("rnd_core_en", 32'(cnt_en), 32'(n_in));
    chk("rnd_left", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/biquad_stereo_sequencer.md
# biquad_stereo_sequencer

Front-end controller that drives a pair of external mono biquad cores, one for L and one for R, and sits between the stereo sample stream and the filter datapath. It accepts stereo frames over a valid/ready handshake and issues one core enable per frame. It captures both core outputs after the fixed core latency and presents them on a backpressured output stream. It also owns the active coefficient set, double-buffered so that updates commit atomically between frames, and it sequences core state flushes.

## Interface
- CORE_LAT, 1: cycles from a core_en cycle until core_y_l/core_y_r are valid; legal range 1..7.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_valid / s_ready  in / out  1  input frame handshake.
- s_data_l, s_data_r  in  16  input samples, Q1.15 signed.
- m_valid / m_ready  out / in  1  output frame handshake.
- m_data_l, m_data_r  out  16  filtered samples, Q1.15 signed.
- core_en  out  1  one-cycle enable to both cores.
- core_rst  out  1  active-high synchronous reset to both cores.
- core_x_l, core_x_r  out  16  samples to the cores.
- core_y_l, core_y_r  in  16  core outputs.
- coef_b0, coef_b1, coef_b2, coef_a1, coef_a2  out  16  active coefficients, Q1.15, shared by both cores.
- cfg_we  in  1  shadow coefficient write strobe.
- cfg_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 ignored.
- cfg_wdata  in  16  shadow write data.
- cfg_commit  in  1  request to copy shadow to active.
- cfg_pending  out  1  commit requested and not yet applied.
- flush  in  1  request to clear core filter state.

## Operation
- FSM states:
  - IDLE → ISSUE on s_valid&&s_ready.
  - ISSUE is one cycle → WAIT.
  - WAIT lasts CORE_LAT cycles. On the edge ending the last WAIT cycle: m_data ← core_y, then → OUT.
  - OUT → IDLE on m_valid&&m_ready.
- s_ready = (state==IDLE) && !rst_n_q && !flush_pend && !cfg_pending. Registered or combinational, but it must obey this equation.
- core_x_l/core_x_r are loaded from s_data on the accepting edge and hold until the next accept.
- core_en is 1 exactly during ISSUE.
- m_valid is 1 exactly during OUT. m_data holds stable while m_valid && !m_ready.
- cfg_we writes shadow[cfg_addr] in any state. Writes to addresses 5..7 have no effect.
- cfg_commit sets cfg_pending. A second commit while pending has no additional effect.
- Commit apply: in IDLE with cfg_pending=1, one cycle copies all five shadow registers to active (coef_* update on that edge) and clears cfg_pending.
- If cfg_we coincides with the apply cycle: the copy takes the pre-write shadow value, and the new write remains in shadow.
- A commit requested outside IDLE applies only after the in-flight frame completes. Coefficients therefore never change between ISSUE and capture.
- flush is latched into flush_pend in any state. It is applied in IDLE: core_rst=1 for one cycle, and flush_pend clears on that edge.
- Flush and commit may be applied in the same IDLE cycle. No frame is accepted in an apply cycle.
- Arithmetic: none. Samples and coefficients pass through unmodified.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE, m_valid=0, core_en=0, core_rst=1.
  - core_x_*=0, m_data_*=0, cfg_pending=0, flush_pend=0.
  - Active and shadow coefficients: b0=0x7FFF, b1=b2=a1=a2=0 (passthrough).
- core_rst stays 1 for the first cycle after rst_n rises. rst_n_q is a one-cycle delayed reset flag, so s_ready=0 in that cycle. s_ready=1 from the second cycle.
- Reset asserted mid-frame abandons the frame: no m_valid, and the cores are reset via core_rst.
- Latency: accept edge E0; core_en high during the cycle after E0; m_valid high after edge E0+1+CORE_LAT.
- Minimum frame period with m_ready held 1: 3+CORE_LAT cycles (4 for the default).
- m_ready held 0 stalls in OUT indefinitely. s_ready stays 0 until release.

## Test plan
- Reset, then frame L=0x4000, R=0xC000 with default coefficients and real cores → m_data_l=0x3FFF, m_data_r=0xC000; m_valid rises 2 cycles after accept.
- Back-to-back frames with m_ready=1 → s_ready pulses once every 4 cycles; core_en pulses once per frame; no frame is dropped or duplicated.
- Hold m_ready=0 for 10 cycles in OUT → m_data is stable, s_ready=0, and no core_en pulse occurs; release → handshake completes and IDLE is reached next cycle.
- Write b0=0x2000 and commit during WAIT → cfg_pending=1 until the frame finishes; coef_b0 becomes 0x2000 in the following IDLE; the next frame with L=0x4000 gives 0x1000.
- cfg_we to addr 0 with 0x1000 in the same cycle as the commit apply → coef_b0 takes the prior shadow value; the shadow reads 0x1000 at the next commit.
- flush mid-frame → the current frame's output is correct; core_rst pulses one cycle in IDLE; a subsequent impulse reproduces the initial-state response.
